// File: rtl/prince_sbox_cms_seq.sv
// prince_sbox_cms_seq: feeds the 16 nibbles of a shared PRINCE state, one per
// cycle, into a single pipelined CMS S-box core. Each returned shared nibble is
// written back in place. The substituted state is then offered on a
// valid/ready port.
// Optional build macro PRINCE_CMS_RND_EN: gate each issue on mask randomness
// (rnd_valid/rnd_ready). When it is undefined, the 16 issues run back to back.
module prince_sbox_cms_seq #(
  parameter int NSHARE   = 3,
  parameter int SBOX_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [64*NSHARE-1:0]  in_state,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [64*NSHARE-1:0]  out_state,
  output logic [4*NSHARE-1:0]   sbox_x,
  output logic                  sbox_x_valid,
  input  logic [4*NSHARE-1:0]   sbox_y,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                  r_fsm, w_fsm_nxt;
  logic [64*NSHARE-1:0]        r_st;
  logic [4:0]                  r_issue_cnt, r_ret_cnt;
  logic [4*NSHARE-1:0]         r_sbx;
  logic                        r_sbx_vld;
  logic [3:0]                  r_sbx_idx;
  logic [SBOX_LAT-1:0]         r_tag_vld;
  logic [SBOX_LAT-1:0][3:0]    r_tag_idx;

  logic                        w_accept, w_issue_ok, w_issue, w_tag_out;
  logic [3:0]                  w_tag_idx;
  logic [4*NSHARE-1:0]         w_nib;

`ifdef PRINCE_CMS_RND_EN
  assign w_issue_ok = rnd_valid;
  assign rnd_ready  = w_issue;
`else
  logic w_unused_rnd;
  assign w_unused_rnd = rnd_valid;
  assign w_issue_ok   = 1'b1;
  assign rnd_ready    = 1'b0;
`endif

  assign w_accept  = (r_fsm == S_IDLE) && in_valid;
  assign w_issue   = (r_fsm == S_ISSUE) && w_issue_ok && (r_issue_cnt < 5'd16);
  assign w_tag_out = r_tag_vld[SBOX_LAT-1];
  assign w_tag_idx = r_tag_idx[SBOX_LAT-1];

  // Select nibble issue_cnt from every share.
  for (genvar s = 0; s < NSHARE; s++) begin : g_nib
    assign w_nib[4*s +: 4] = r_st[64*s + 4*r_issue_cnt[3:0] +: 4];
  end

  assign in_ready  = (r_fsm == S_IDLE);
  assign out_valid = (r_fsm == S_DONE);
  assign busy      = (r_fsm != S_IDLE);
  assign out_state = r_st;
  assign sbox_x    = r_sbx;
  assign sbox_x_valid = r_sbx_vld;

  // Next-state logic. DRAIN also leaves on the same edge that captures the last return.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE:  if (in_valid) w_fsm_nxt = S_ISSUE;
      S_ISSUE: if (w_issue && r_issue_cnt == 5'd15) w_fsm_nxt = S_DRAIN;
      S_DRAIN: if (r_ret_cnt == 5'd16 || (w_tag_out && r_ret_cnt == 5'd15))
                 w_fsm_nxt = S_DONE;
      S_DONE:  if (out_ready) w_fsm_nxt = S_IDLE;
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // FSM state and saturating issue/return counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_issue_cnt <= 5'd0;
      r_ret_cnt   <= 5'd0;
    end else begin
      r_fsm <= w_fsm_nxt;
      if (w_accept) begin
        r_issue_cnt <= 5'd0;
        r_ret_cnt   <= 5'd0;
      end else begin
        if (w_issue) r_issue_cnt <= r_issue_cnt + 5'd1;
        if (w_tag_out && r_ret_cnt < 5'd16) r_ret_cnt <= r_ret_cnt + 5'd1;
      end
    end
  end

  // Registered issue port. Idle cycles drive zeros, so no stale share is left on the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sbx     <= '0;
      r_sbx_vld <= 1'b0;
      r_sbx_idx <= 4'd0;
    end else if (w_issue) begin
      r_sbx     <= w_nib;
      r_sbx_vld <= 1'b1;
      r_sbx_idx <= r_issue_cnt[3:0];
    end else begin
      r_sbx     <= '0;
      r_sbx_vld <= 1'b0;
      r_sbx_idx <= 4'd0;
    end
  end

  // Tag shift register tracking the core latency. It advances every cycle, regardless of stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      r_tag_idx <= '0;
    end else begin
      r_tag_vld[0] <= r_sbx_vld;
      r_tag_idx[0] <= r_sbx_idx;
      for (int k = 1; k < SBOX_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_idx[k] <= r_tag_idx[k-1];
      end
    end
  end

  // State register: load on accept. Write returns in place; a nibble only
  // returns after it has been issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st <= '0;
    end else if (w_accept) begin
      r_st <= in_state;
    end else if (w_tag_out) begin
      for (int s = 0; s < NSHARE; s++)
        r_st[64*s + 4*w_tag_idx +: 4] <= sbox_y[4*s +: 4];
    end
  end

endmodule

// File: tb/tb_prince_sbox_cms_seq.sv
// Bench for prince_sbox_cms_seq: a stub S-box core plus a timing and data
// model derived from the issue pattern. Covers the directed cases and
// randomized operations.
module tb_prince_sbox_cms_seq;
  localparam int NSHARE   = 3;
  localparam int SBOX_LAT = 2;
  localparam int W        = 64*NSHARE;
`ifdef PRINCE_CMS_RND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [W-1:0] in_state = '0, out_state;
  logic [4*NSHARE-1:0] sbox_x, sbox_y;
  logic sbox_x_valid, rnd_valid = 1'b0, rnd_ready, busy;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  prince_sbox_cms_seq #(.NSHARE(NSHARE), .SBOX_LAT(SBOX_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .sbox_x(sbox_x), .sbox_x_valid(sbox_x_valid),
    .sbox_y(sbox_y), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .busy(busy));

  function automatic logic [3:0] sb(input logic [3:0] v);
    case (v)
      4'h0: sb = 4'hB; 4'h1: sb = 4'hF; 4'h2: sb = 4'h3; 4'h3: sb = 4'h2;
      4'h4: sb = 4'hA; 4'h5: sb = 4'hC; 4'h6: sb = 4'h9; 4'h7: sb = 4'h1;
      4'h8: sb = 4'h6; 4'h9: sb = 4'h7; 4'hA: sb = 4'h8; 4'hB: sb = 4'h0;
      4'hC: sb = 4'hE; 4'hD: sb = 4'h5; 4'hE: sb = 4'hD; default: sb = 4'h4;
    endcase
  endfunction

  function automatic logic [63:0] sb64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = sb(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] st);
    return {128'b0, sb64(st[63:0] ^ st[127:64] ^ st[191:128])};
  endfunction

  // Stub core: recombine, substitute, return on share 0 after SBOX_LAT cycles.
  logic [4*NSHARE-1:0] y1, y2;
  always @(posedge clk) begin
    y1 <= {8'b0, sb(sbox_x[3:0] ^ sbox_x[7:4] ^ sbox_x[11:8])};
    y2 <= y1;
  end
  assign sbox_y = y2;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_in_ready"},  in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sbox_x"},    sbox_x, 0);
    chk({tag, "_sbox_x_vld"}, sbox_x_valid, 0);
    chk({tag, "_rnd_ready"}, rnd_ready, 0);
    chk({tag, "_busy"},      busy, 0);
  endtask

  // One operation. mode selects rnd_valid: 0 = always high, 1 = random, 2 = low in cycles 3 and 9.
  // abort_k >= 0 asserts reset in that cycle and returns.
  task automatic run_op(input logic [W-1:0] st, input logic [W-1:0] expv,
                        input int hold, input int mode, input int abort_k);
    bit rv[64];
    bit iss[64];
    int cnt, jlast, exp_ov, nib;
    logic [4*NSHARE-1:0] ex;
    for (int k = 0; k < 64; k++)
      rv[k] = (mode == 0) ? 1'b1 :
              (mode == 1) ? (($urandom_range(0, 3) != 0) || k >= 40) :
                            (k != 3 && k != 9);
    cnt = 0; jlast = 0;
    for (int k = 0; k < 64; k++) begin
      iss[k] = (RND ? rv[k] : 1'b1) && (cnt < 16);
      if (iss[k]) begin
        cnt++;
        if (cnt == 16) jlast = k;
      end
    end
    exp_ov = jlast + 2 + SBOX_LAT;
    @(negedge clk);
    out_ready = (hold == 0);
    in_state  = st;
    in_valid  = 1'b1;
    rnd_valid = 1'($urandom_range(0, 1));
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_state  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rnd_valid = rv[0];
    nib = 0;
    for (int k = 0; k <= exp_ov; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        rnd_valid = rv[k];
      end
      if (k == abort_k) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      chk("sbox_x_valid", sbox_x_valid, (k > 0) && iss[k-1]);
      if (sbox_x_valid) begin
        for (int s = 0; s < NSHARE; s++) ex[4*s +: 4] = st[64*s + 4*nib +: 4];
        chk("sbox_x_data", sbox_x, ex);
        nib++;
      end else begin
        chk("sbox_x_idle", sbox_x, 0);
      end
      chk("rnd_ready", rnd_ready, RND && iss[k]);
      chk("busy", busy, 1);
      chk("in_ready_busy", in_ready, 0);
      chk("out_valid_time", out_valid, k == exp_ov);
      if (k == exp_ov) chk("out_state", out_state, expv);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_state", out_state, expv);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_sbox_x_vld", sbox_x_valid, 0);
  endtask

  function automatic logic [W-1:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [63:0] x, m;
    logic [W-1:0] st, basic_st, basic_exp;
    #2;
    chk_reset_outs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    x = 64'h0123456789ABCDEF;
    basic_st  = {128'b0, x};
    basic_exp = {128'b0, 64'hBF32AC916780E5D4};
    run_op(basic_st, basic_exp, 0, 0, -1);

    m = 64'hA5A5A5A5A5A5A5A5;
    run_op({64'b0, m, x ^ m}, basic_exp, 0, 0, -1);

    st = rand_state();
    run_op(st, model(st), 10, 0, -1);

    st = rand_state();
    run_op(st, model(st), 0, 0, 8);
    run_op(basic_st, basic_exp, 0, 0, -1);

    run_op(basic_st, basic_exp, 0, 2, -1);

    for (int i = 0; i < 20; i++) begin
      st = rand_state();
      run_op(st, model(st), int'($urandom_range(0, 3)), 1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1);
  end
endmodule
